// File: rtl/stream_mux_n_1.sv
// N-to-1 valid/ready stream multiplexer with a single registered output stage.
// MODE=0 grants the channel named by sel; MODE=1 grants round-robin from ptr.
module stream_mux_n_1 #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned MODE  = 0,
    localparam int unsigned SW   = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SW-1:0]    sel,
    input  logic [N-1:0]     in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]     in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [SW-1:0]    out_ch,
    input  logic             out_ready
);

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [SW-1:0]    out_ch_q;
    logic [SW-1:0]    ptr_q;
    logic [SW-1:0]    ptr_nxt;

    logic             grant_vld;
    logic [SW-1:0]    grant;
    logic [WIDTH-1:0] grant_data;
    logic             load_en;
    logic             xfer;

    // Output register may load when empty or draining this cycle.
    assign load_en = !out_valid_q || out_ready;
    assign xfer    = grant_vld && load_en && !rst;

    // Grant selection: external select or first valid channel at/after ptr.
    always_comb begin
        int unsigned idx;
        logic [N-1:0] shifted;
        grant_vld = 1'b0;
        grant     = '0;
        idx       = 0;
        shifted   = '0;
        if (MODE == 0) begin
            // sel values >= N match no channel and so produce no grant
            for (int i = 0; i < N; i++) begin
                if (sel == SW'(i) && in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant     = SW'(i);
                end
            end
        end else begin
            // Walk furthest-first so the nearest valid channel to ptr wins.
            for (int unsigned k = N; k > 0; k--) begin
                idx     = (32'(ptr_q) + k - 1) % N;
                shifted = in_valid >> idx;
                if (shifted[0]) begin
                    grant_vld = 1'b1;
                    grant     = SW'(idx);
                end
            end
        end
    end

    // Data mux and one-hot ready for the granted channel.
    always_comb begin
        grant_data = '0;
        in_ready   = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == SW'(i)) begin
                grant_data  = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = xfer;
            end
        end
    end

    // Pointer advances past the channel just served, wrapping at N-1.
    always_comb begin
        if (32'(grant) == N - 1) begin
            ptr_nxt = '0;
        end else begin
            ptr_nxt = grant + 1'b1;
        end
    end

    // Output stage and arbitration pointer; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= grant_data;
            out_ch_q    <= grant;
            ptr_q       <= ptr_nxt;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: doc/stream_mux_n_1.md
STREAM_MUX_N_1 -- requirements
Module: stream_mux_n_1

Interface
REQ-001 Parameter WIDTH, default 8: data bits per channel; legal range 1..64.
REQ-002 Parameter N, default 4: input channel count; legal range 2..16.
REQ-003 Parameter MODE, default 0: 0 = external select, 1 = round-robin arbitration.
REQ-004 Derived localparam SW = $clog2(N): select and channel-ID width.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 sel  input  SW  channel select, used only when MODE=0.
REQ-008 in_valid  input  N  per-channel valid, bit i = channel i.
REQ-009 in_data  input  N*WIDTH  packed channel data, channel i at bits [i*WIDTH +: WIDTH].
REQ-010 in_ready  output  N  per-channel ready, one-hot or zero.
REQ-011 out_valid  output  1  output register holds a word.
REQ-012 out_data  output  WIDTH  registered selected word.
REQ-013 out_ch  output  SW  source channel index of out_data.
REQ-014 out_ready  input  1  downstream accepts when high with out_valid.

Function
REQ-015 Transfer on a channel SHALL occur in any cycle where in_valid[i] and in_ready[i] are both high; output transfer when out_valid and out_ready are both high.
REQ-016 Output register SHALL be loadable when out_valid=0 or out_ready=1 (load_en); full-throughput back-to-back transfers SHALL be supported.
REQ-017 in_ready SHALL be combinational: in_ready[g]=load_en for granted channel g, all other bits 0; in_ready SHALL NOT depend on in_valid of non-granted channels.
REQ-018 MODE=0: grant SHALL be channel sel if in_valid[sel]=1, else no grant; sel >= N SHALL produce no grant.
REQ-019 MODE=1: grant SHALL be the first channel with in_valid=1 searching ptr, ptr+1, ..., wrapping modulo N; no grant if all in_valid=0.
REQ-020 MODE=1: ptr SHALL update to (g+1) mod N only on a completed input transfer; ptr SHALL hold when stalled or idle; wrap from N-1 to 0.
REQ-021 Latency SHALL be exactly 1 cycle: word accepted at edge k appears on out_data/out_ch with out_valid=1 after edge k.
REQ-022 On input transfer, out_data<=in_data of g, out_ch<=g, out_valid<=1.
REQ-023 On output transfer with no simultaneous input transfer, out_valid<=0; out_data and out_ch SHALL hold their last values.
REQ-024 Simultaneous output and input transfer SHALL replace the word with no bubble; out_valid remains 1.
REQ-025 While out_valid=1 and out_ready=0, out_data, out_ch, ptr SHALL be stable and all in_ready SHALL be 0.
REQ-026 No word SHALL be duplicated or dropped; per-channel ordering SHALL be preserved.
REQ-027 Grant changes (sel change, new in_valid) SHALL take effect in the same cycle; no grant lock across stalls is required.

Reset
REQ-028 When rst=1 at a rising edge: out_valid<=0, out_data<=0, out_ch<=0, ptr<=0.
REQ-029 While rst=1, in_ready SHALL be all 0; reset mid-transfer SHALL discard the held word without emitting it.
REQ-030 rst SHALL take priority over every other update in the same cycle.

Verification
REQ-031 MODE=0, N=4, WIDTH=8, out_ready=1, sel=2, in_valid=4'b0100, ch2 data=8'hA5 -> in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_ch=2.
REQ-032 MODE=1, all in_valid=1, data ch i=8'h10+i, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3, one word per cycle, no bubbles.
REQ-033 MODE=1, in_valid=4'b1010, ptr=0 -> grant ch1; then ptr=2 -> grant ch3; then ptr=0 -> grant ch1 (wrap verified).
REQ-034 Backpressure: out_valid=1, out_ready=0 for 3 cycles with new inputs valid -> out_data unchanged, in_ready=0 throughout; on out_ready=1, held word completes and next word loads same edge.
REQ-035 rst=1 asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0, out_ch=0; after rst=0, MODE=1 arbitration restarts from ch0.
REQ-036 MODE=0, sel=3, in_valid=4'b0111 -> in_ready=0, no transfer, out_valid stays 0.
